// File: rtl/vec_addsub.sv
// Multi-lane float add/subtract: lanes are processed one after another through a
// single shared adder; operand and result negation is a sign-bit flip.

module adder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned EXP_W      = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] sum
);
  localparam int unsigned MAN_W = DATA_WIDTH - 1 - EXP_W;
  localparam int unsigned F     = MAN_W + 4;  // hidden + fraction + guard/round/sticky

  logic                  sa, sb, sl, ss, up;
  logic [EXP_W-1:0]      ea, eb, el, es;
  logic [MAN_W-1:0]      fa, fb, fl, fs;
  logic [F-1:0]          ml, ms;
  logic [F:0]            acc;
  logic [EXP_W+1:0]      e, d;
  logic [MAN_W+1:0]      mr;
  logic [DATA_WIDTH-1:0] res;

  always_comb begin
    res = '0;
    {sa, ea, fa} = in1;
    {sb, eb, fb} = in2;
    sl = 1'b0; el = '0; fl = '0;
    ss = 1'b0; es = '0; fs = '0;
    ml = '0; ms = '0; acc = '0; e = '0; d = '0; mr = '0; up = 1'b0;
    if ((&ea) && (|fa)) begin
      res = in1;
    end else if ((&eb) && (|fb)) begin
      res = in2;
    end else if ((&ea) && (&eb) && (sa != sb)) begin
      res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (&ea) begin
      res = in1;
    end else if (&eb) begin
      res = in2;
    end else begin
      if ({ea, fa} >= {eb, fb}) begin
        sl = sa; el = ea; fl = fa; ss = sb; es = eb; fs = fb;
      end else begin
        sl = sb; el = eb; fl = fb; ss = sa; es = ea; fs = fa;
      end
      ml = {|el, fl, 3'b000};
      ms = {|es, fs, 3'b000};
      e  = {2'b00, (el == '0) ? EXP_W'(1) : el};
      d  = e - {2'b00, (es == '0) ? EXP_W'(1) : es};
      // Alignment shift folds every bit shifted out into the sticky LSB.
      for (int unsigned i = 0; i <= F; i++)
        if (i < 32'(d)) ms = {1'b0, ms[F-1:2], ms[1] | ms[0]};
      acc = (sl == ss) ? ({1'b0, ml} + {1'b0, ms}) : ({1'b0, ml} - {1'b0, ms});
      if (acc == '0) begin
        res = {sl & ss, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        if (acc[F]) begin
          acc = {1'b0, acc[F:2], acc[1] | acc[0]};
          e   = e + 1'b1;
        end
        for (int unsigned i = 0; i < F; i++)
          if (!acc[F-1] && (e > (EXP_W+2)'(1))) begin
            acc = acc << 1;
            e   = e - 1'b1;
          end
        up = acc[2] & (acc[1] | acc[0] | acc[3]);
        mr = {1'b0, acc[F-1:3]} + {{(MAN_W+1){1'b0}}, up};
        if (mr[MAN_W+1]) begin
          mr = mr >> 1;
          e  = e + 1'b1;
        end
        if (e >= {2'b00, {EXP_W{1'b1}}})
          res = {sl, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
          res = {sl, mr[MAN_W] ? e[EXP_W-1:0] : {EXP_W{1'b0}}, mr[MAN_W-1:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done <= 1'b0;
      sum  <= '0;
    end else if (start && !done) begin
      sum  <= res;
      done <= 1'b1;
    end else if (!start) begin
      done <= 1'b0;
    end
  end
endmodule

module vec_addsub #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [LANES-1:0]            lane_mask,
  input  logic [DATA_WIDTH*LANES-1:0] value_a,
  input  logic [DATA_WIDTH*LANES-1:0] value_b,
  output logic                        busy,
  output logic                        done,
  output logic [DATA_WIDTH*LANES-1:0] value_out
);
  localparam int unsigned CNT_W = $clog2(LANES) + 1;
  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [DATA_WIDTH-1:0] SIGN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LANE  = 3'd1,
    S_SETUP = 3'd2,
    S_WAIT  = 3'd3,
    S_ACK   = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic [IDX_W-1:0]            idx;
  logic [1:0]                  mode_q;
  logic [LANES-1:0]            mask_q;
  logic [DATA_WIDTH*LANES-1:0] a_q, b_q;
  logic [DATA_WIDTH-1:0]       add_in1, add_in2, add_sum, a_lane, b_lane;
  logic                        add_start, add_done;

  assign idx    = cnt[IDX_W-1:0];
  assign a_lane = a_q[idx*DATA_WIDTH +: DATA_WIDTH];
  assign b_lane = b_q[idx*DATA_WIDTH +: DATA_WIDTH];

  adder #(.DATA_WIDTH(DATA_WIDTH), .EXP_W(8)) u_adder (
    .clk   (clk),
    .rstn  (rstn),
    .start (add_start),
    .in1   (add_in1),
    .in2   (add_in2),
    .done  (add_done),
    .sum   (add_sum)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mode_q    <= '0;
      mask_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      add_in1   <= '0;
      add_in2   <= '0;
      add_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      value_out <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mode_q <= mode;
          mask_q <= lane_mask;
          a_q    <= value_a;
          b_q    <= value_b;
          busy   <= 1'b1;
          cnt    <= '0;
          state  <= S_LANE;
        end
        S_LANE: begin
          if (!mask_q[idx]) begin
            value_out[idx*DATA_WIDTH +: DATA_WIDTH] <= a_lane;
            state <= S_NEXT;
          end else begin
            add_in1 <= (mode_q == 2'b10) ? (a_lane ^ SIGN) : a_lane;
            add_in2 <= (mode_q == 2'b01) ? (b_lane ^ SIGN) : b_lane;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          add_start <= 1'b1;
          state     <= S_WAIT;
        end
        S_WAIT: if (add_done) begin
          value_out[idx*DATA_WIDTH +: DATA_WIDTH] <=
            (mode_q == 2'b11) ? (add_sum ^ SIGN) : add_sum;
          add_start <= 1'b0;
          state     <= S_ACK;
        end
        S_ACK: if (!add_done) state <= S_NEXT;
        S_NEXT: begin
          if (cnt == CNT_W'(LANES - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= S_LANE;
          end
        end
        S_DONE: if (!start) begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
